// File: rtl/restoring_divider.sv
`default_nettype none
// ============================================================================
//  Module   : restoring_divider
//  Purpose  : Sequential unsigned restoring divider. Divides a 2N-bit
//             dividend by an N-bit divisor and produces one quotient bit per
//             clock, so a result takes 2N iterations. A zero divisor
//             bypasses the iterations and returns a flagged saturated result.
//  Ports    : clk          - single clock, rising edge
//             rst          - synchronous active-high reset
//             in_valid     - operand pair offered
//             in_ready     - block can accept operands (IDLE only)
//             IN1 [2N-1:0] - unsigned dividend
//             IN2 [N-1:0]  - unsigned divisor
//             out_valid    - result present (DONE only)
//             out_ready    - consumer accepts result
//             Quot[2N-1:0] - unsigned quotient
//             Rem [N-1:0]  - unsigned remainder
//             div_by_zero  - result came from IN2 == 0
//  Revision : 1.0 - initial release
// ============================================================================
module restoring_divider #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*N-1:0] IN1,
    input  logic [N-1:0]   IN2,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] Quot,
    output logic [N-1:0]   Rem,
    output logic           div_by_zero
);

    localparam int CW = $clog2(2 * N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_next_state;

    logic [CW-1:0]  r_cnt;
    // The partial remainder is always strictly below the divisor between
    // iterations, so N bits hold it; only the shifted trial value needs N+1.
    logic [N-1:0]   r_prem;
    logic [2*N-1:0] r_quo;
    logic [N-1:0]   r_dvs;

    logic [N:0]     w_shift;
    logic           w_fits;
    logic [N-1:0]   w_diff;
    logic [N-1:0]   w_prem_next;
    logic [2*N-1:0] w_quo_next;
    logic           w_last;

    // One restoring step: shift the next dividend bit into the remainder,
    // then keep the difference only when the divisor fits.
    assign w_shift     = {r_prem, r_quo[2*N-1]};
    assign w_fits      = (w_shift >= {1'b0, r_dvs});
    // When the divisor fits the difference is below 2^N, so the low N bits
    // of a modulo-2^N subtraction are exact.
    assign w_diff      = w_shift[N-1:0] - r_dvs;
    assign w_prem_next = w_fits ? w_diff : w_shift[N-1:0];
    assign w_quo_next  = {r_quo[2*N-2:0], w_fits};
    assign w_last      = (r_cnt == '0);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_next_state = (IN2 == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath. Result registers are written only when entering DONE, so
    // they keep the last result everywhere else.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_prem      <= '0;
            r_quo       <= '0;
            r_dvs       <= '0;
            Quot        <= '0;
            Rem         <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_dvs <= IN2;
                        if (IN2 == '0) begin
                            Quot        <= '1;
                            Rem         <= IN1[N-1:0];
                            div_by_zero <= 1'b1;
                        end else begin
                            r_cnt  <= CW'(2 * N - 1);
                            r_prem <= '0;
                            r_quo  <= IN1;
                        end
                    end
                end
                RUN: begin
                    r_prem <= w_prem_next;
                    r_quo  <= w_quo_next;
                    r_cnt  <= r_cnt - 1'b1;
                    if (w_last) begin
                        Quot        <= w_quo_next;
                        Rem         <= w_prem_next;
                        div_by_zero <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_restoring_divider.sv
`default_nettype none
// ============================================================================
//  Module   : tb_restoring_divider
//  Purpose  : Self-checking bench for restoring_divider (N = 8). Directed
//             scenarios cover reset, latency, zero divisor, back-pressure and
//             reset mid-operation; a randomized run compares every result
//             with an arithmetic reference model through an in-order queue.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_restoring_divider;

    localparam int N       = 8;
    localparam int NPAIRS  = 2500;
    localparam int CYC_LIM = 90000;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [2*N-1:0] IN1;
    logic [N-1:0]   IN2;
    logic           out_valid;
    logic           out_ready;
    logic [2*N-1:0] Quot;
    logic [N-1:0]   Rem;
    logic           div_by_zero;

    int errors = 0;
    int checks = 0;

    restoring_divider #(.N(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .IN1         (IN1),
        .IN2         (IN2),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .Quot        (Quot),
        .Rem         (Rem),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    // Advance one cycle; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: plain integer division, saturated result for zero divisor.
    task automatic ref_div(input logic [2*N-1:0] a, input logic [N-1:0] b,
                           output logic [2*N-1:0] q, output logic [N-1:0] r,
                           output logic z);
        if (b == 0) begin
            q = '1;
            r = a[N-1:0];
            z = 1'b1;
        end else begin
            q = a / b;
            r = N'(a % b);
            z = 1'b0;
        end
    endtask

    // Offer one operand pair, then return the cycle count until out_valid
    // (acceptance cycle = 0); -1 if it never appears.
    task automatic drive_op(input logic [2*N-1:0] a, input logic [N-1:0] b,
                            output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 64) begin
            step();
            guard++;
        end
        in_valid = 1'b1;
        IN1      = a;
        IN2      = b;
        step();
        in_valid = 1'b0;
        IN1      = 16'($urandom);
        IN2      = 8'($urandom);
        lat      = 1;
        while (!out_valid && lat < 64) begin
            step();
            lat++;
        end
        if (!out_valid) lat = -1;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        in_valid = 1'b1;
        IN1      = 16'd100;
        IN2      = 8'd7;
        step();
        step();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_hs: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
        end
        checks++;
        if (Quot !== 16'd0 || Rem !== 8'd0 || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_data: Quot=%0d Rem=%0d dbz=%b expected 0/0/0", Quot, Rem, div_by_zero);
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        step();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_no_accept: in_ready=%b expected 1", in_ready);
        end
    endtask

    task automatic test_basic();
        int lat;
        out_ready = 1'b1;
        drive_op(16'd100, 8'd7, lat);
        checks++;
        if (lat !== 17) begin
            errors++;
            $display("FAIL basic_latency: got %0d expected 17", lat);
        end
        checks++;
        if (Quot !== 16'd14 || Rem !== 8'd2 || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL basic_result: Quot=%0d Rem=%0d dbz=%b expected 14/2/0", Quot, Rem, div_by_zero);
        end
        step();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_drain: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_div_zero();
        int lat;
        out_ready = 1'b1;
        drive_op(16'd1234, 8'd0, lat);
        checks++;
        if (lat !== 1) begin
            errors++;
            $display("FAIL dbz_latency: got %0d expected 1", lat);
        end
        checks++;
        if (Quot !== 16'hFFFF || Rem !== 8'd210 || div_by_zero !== 1'b1) begin
            errors++;
            $display("FAIL dbz_result: Quot=%0d Rem=%0d dbz=%b expected 65535/210/1", Quot, Rem, div_by_zero);
        end
        step();
    endtask

    task automatic test_corners();
        logic [2*N-1:0] ta [4];
        logic [N-1:0]   tb [4];
        logic [2*N-1:0] eq;
        logic [N-1:0]   er;
        logic           ez;
        int             lat;
        ta = '{16'd65535, 16'd40000, 16'd0, 16'd255};
        tb = '{8'd255,    8'd1,      8'd5,  8'd16};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ref_div(ta[i], tb[i], eq, er, ez);
            drive_op(ta[i], tb[i], lat);
            checks++;
            if (lat !== 17 || Quot !== eq || Rem !== er || div_by_zero !== ez) begin
                errors++;
                $display("FAIL corner_%0d: lat=%0d Quot=%0d Rem=%0d dbz=%b expected 17/%0d/%0d/%b",
                         i, lat, Quot, Rem, div_by_zero, eq, er, ez);
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        out_ready = 1'b0;
        drive_op(16'd1000, 8'd3, lat);
        checks++;
        if (lat !== 17) begin
            errors++;
            $display("FAIL bp_latency: got %0d expected 17", lat);
        end
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            IN1      = 16'($urandom);
            IN2      = 8'($urandom);
            step();
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || Quot !== 16'd333 || Rem !== 8'd1 ||
                div_by_zero !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold_%0d: ov=%b ir=%b Quot=%0d Rem=%0d dbz=%b expected 1/0/333/1/0",
                         i, out_valid, in_ready, Quot, Rem, div_by_zero);
            end
        end
        // Release while still offering operands: no same-cycle drain and accept.
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid  = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || Quot !== 16'd333 || Rem !== 8'd1) begin
            errors++;
            $display("FAIL bp_release: ir=%b ov=%b Quot=%0d Rem=%0d expected 1/0/333/1",
                     in_ready, out_valid, Quot, Rem);
        end
    endtask

    task automatic test_reset_in_run();
        int  lat;
        logic seen;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        IN1       = 16'd50000;
        IN2       = 8'd7;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || Quot !== 16'd0 || Rem !== 8'd0 ||
            div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL rst_run: ov=%b ir=%b Quot=%0d Rem=%0d dbz=%b expected 0/1/0/0/0",
                     out_valid, in_ready, Quot, Rem, div_by_zero);
        end
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) seen = 1'b1;
            step();
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL rst_run_discard: out_valid seen=%b expected 0", seen);
        end
        drive_op(16'd9, 8'd4, lat);
        checks++;
        if (lat !== 17 || Quot !== 16'd2 || Rem !== 8'd1 || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL rst_run_after: lat=%0d Quot=%0d Rem=%0d dbz=%b expected 17/2/1/0",
                     lat, Quot, Rem, div_by_zero);
        end
        step();
    endtask

    task automatic test_random();
        logic [2*N-1:0] q_quot [$];
        logic [N-1:0]   q_rem  [$];
        logic           q_dbz  [$];
        logic [2*N-1:0] eq;
        logic [N-1:0]   er;
        logic           ez;
        int accepted;
        int cyc;
        accepted = 0;
        cyc      = 0;
        while ((accepted < NPAIRS || q_quot.size() != 0) && cyc < CYC_LIM) begin
            in_valid  = (accepted < NPAIRS) && ($urandom_range(0, 3) != 0);
            IN1       = 16'($urandom);
            IN2       = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            if (out_valid && out_ready) begin
                checks++;
                if (q_quot.size() == 0) begin
                    errors++;
                    $display("FAIL rand_extra: unexpected result Quot=%0d Rem=%0d", Quot, Rem);
                end else begin
                    eq = q_quot.pop_front();
                    er = q_rem.pop_front();
                    ez = q_dbz.pop_front();
                    if (Quot !== eq || Rem !== er || div_by_zero !== ez) begin
                        errors++;
                        $display("FAIL rand_result: Quot=%0d Rem=%0d dbz=%b expected %0d/%0d/%b",
                                 Quot, Rem, div_by_zero, eq, er, ez);
                    end
                end
            end
            if (in_valid && in_ready) begin
                ref_div(IN1, IN2, eq, er, ez);
                q_quot.push_back(eq);
                q_rem.push_back(er);
                q_dbz.push_back(ez);
                accepted++;
            end
            step();
            cyc++;
        end
        in_valid = 1'b0;
        checks++;
        if (accepted != NPAIRS || q_quot.size() != 0) begin
            errors++;
            $display("FAIL rand_complete: accepted=%0d pending=%0d expected %0d/0",
                     accepted, q_quot.size(), NPAIRS);
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        IN1       = '0;
        IN2       = '0;
        test_reset();
        test_basic();
        test_div_zero();
        test_corners();
        test_backpressure();
        test_reset_in_run();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
